// File: rtl/avalon_st_arbiter_pkg.sv
// Shared definitions for the Avalon-ST packet arbiter and related schedulers.
//   ST_IDLE / ST_BUSY : arbiter state encoding
//   DEF_DATA_W        : default data width per source
//   DEF_MAX_BEATS     : default beat limit per packet
//   RR_MAX_SRC        : widest request vector rr_next() handles
//   rr_next()         : round-robin search for the next requester
package avalon_st_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 16;
  localparam int RR_MAX_SRC    = 4;

  // Returns the first set bit of req found by searching upward from last+1,
  // wrapping modulo num. Candidates are visited farthest-first so the nearest
  // one overwrites the result. Returns last when req has no bit set; callers
  // qualify the result with |req.
  function automatic logic [1:0] rr_next(input logic [RR_MAX_SRC-1:0] req,
                                         input logic [1:0]            last,
                                         input int                    num);
    logic [1:0] res;
    int         cand;
    res = last;
    for (int k = RR_MAX_SRC; k >= 1; k--) begin
      if (k <= num) begin
        cand = (int'(last) + k) % num;
        if (req[cand[1:0]]) res = cand[1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_st_arbiter_if.sv
// Streaming bundle between NUM_SRC sources, the arbiter and one sink.
//   in_valid/in_data/in_eop : per-source beat; source i uses in_data[i*DATA_W +: DATA_W]
//   in_ready                : per-source ready back from the arbiter
//   out_valid/out_data/out_eop/out_ready : the shared sink handshake
// Modports: slave = arbiter view, master = environment (sources + sink) view.
interface avalon_st_arbiter_if
  import avalon_st_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = DEF_DATA_W
) ();

  logic [NUM_SRC-1:0]        in_valid;
  logic [NUM_SRC*DATA_W-1:0] in_data;
  logic [NUM_SRC-1:0]        in_eop;
  logic [NUM_SRC-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_eop;
  logic                      out_ready;

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_eop
  );

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_eop
  );

endinterface

// File: rtl/avalon_st_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per source
//   last   : index granted most recently (search starts just above it)
//   found  : 1 when any request is present
//   winner : index of the chosen requester (valid when found=1)
module rr_picker
  import avalon_st_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      winner
);

  logic [RR_MAX_SRC-1:0] req_pad;
  logic [1:0]            last_pad;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_SRC-1:0] = req;
  end

  assign last_pad = 2'(last);
  assign found    = |req;
  assign winner   = IW'(rr_next(req_pad, last_pad, NUM_SRC));

endmodule

// File: rtl/avalon_st_arbiter.sv
// Packet-locked round-robin arbiter sharing one Avalon-ST sink among NUM_SRC
// sources. A granted source owns the sink until its end-of-packet beat is
// accepted, or until MAX_BEATS beats have gone through, in which case the last
// beat is presented with out_eop forced high and trunc_count is bumped.
// Ports:
//   clk         : clock, rising edge
//   resetn      : synchronous reset, active HIGH despite its name
//   st          : streaming bundle (slave modport)
//   grant_id    : owning source, meaningful while busy=1
//   busy        : a packet is in progress
//   trunc_count : forced releases so far, saturating at 255
module avalon_st_arbiter
  import avalon_st_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                       clk,
  input  logic                       resetn,
  avalon_st_arbiter_if.slave         st,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [7:0]                 trunc_count
);

  localparam int GW = $clog2(NUM_SRC);

  logic [0:0]         state;
  logic [GW-1:0]      last_grant;
  logic [7:0]         beat_cnt;
  logic               found;
  logic [GW-1:0]      winner;

  logic               out_valid_c;
  logic [DATA_W-1:0]  out_data_c;
  logic               out_eop_c;
  logic [NUM_SRC-1:0] in_ready_c;
  logic               limit_beat;
  logic               accept;

  // Only consulted in IDLE; in BUSY the lock is held regardless of requests.
  rr_picker #(.NUM_SRC(NUM_SRC), .IW(GW)) u_picker (
    .req    (st.in_valid),
    .last   (last_grant),
    .found  (found),
    .winner (winner)
  );

  assign limit_beat = (beat_cnt == 8'(MAX_BEATS - 1));

  // NOTE: every output of this block gets a default before the BUSY branch,
  // otherwise the IDLE path would hold the old value and infer a latch.
  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = '0;
    out_eop_c   = 1'b0;
    in_ready_c  = '0;
    if (state == ST_BUSY) begin
      out_valid_c          = st.in_valid[grant_id];
      out_data_c           = st.in_data[grant_id*DATA_W +: DATA_W];
      out_eop_c            = st.in_eop[grant_id] | limit_beat;
      in_ready_c[grant_id] = st.out_ready;
    end
  end

  assign accept       = out_valid_c & st.out_ready;
  assign st.out_valid = out_valid_c;
  assign st.out_data  = out_data_c;
  assign st.out_eop   = out_eop_c;
  assign st.in_ready  = in_ready_c;
  assign busy         = (state == ST_BUSY);

  // NOTE: registers are updated with non-blocking assignments so every read
  // in this block sees the pre-edge value, matching the hardware.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_SRC - 1);
      beat_cnt    <= '0;
      trunc_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Grant takes effect next cycle; nothing moves in the IDLE cycle.
          if (found) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        default: begin
          if (accept) begin
            if (out_eop_c) begin
              state      <= ST_IDLE;
              last_grant <= grant_id;
              beat_cnt   <= '0;
              // Released by the beat limit rather than by the source's own eop.
              if (!st.in_eop[grant_id] && trunc_count != 8'hFF)
                trunc_count <= trunc_count + 8'd1;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/avalon_st_arbiter.md
Name: avalon_st_arbiter

Overview:
- Shares one 8-bit Avalon-ST sink between NUM_SRC streaming sources, one packet at a time.
- Round-robin, packet-locked grant: the granted source owns the sink until its end-of-packet beat is accepted.
- A beat limit per packet stops a source from holding the sink forever when its packet never ends.
- Sits between source generators (e.g. fixed-sequence senders) and a single downstream consumer.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..4).
- DATA_W, 8, data width per source in bits.
- MAX_BEATS, 16, maximum beats per packet before forced release (2..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous reset, ACTIVE-HIGH despite the name; sampled on the clk rising edge.
- in_valid  in  NUM_SRC  per-source valid.
- in_data  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- in_eop  in  NUM_SRC  per-source end-of-packet, qualified by in_valid.
- in_ready  out  NUM_SRC  per-source ready.
- out_valid  out  1  sink valid.
- out_data  out  DATA_W  sink data.
- out_eop  out  1  sink end-of-packet; forced to 1 on a truncated final beat.
- out_ready  in  1  sink ready.
- grant_id  out  clog2(NUM_SRC)  index of the owning source; meaningful while busy=1.
- busy  out  1  1 while a packet is in progress.
- trunc_count  out  8  number of forced releases; saturates at 255.

Behaviour:
- Reset (resetn=1 at an edge): state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (so source 0 has first priority), beat_cnt=0, trunc_count=0.
  - Outputs while in reset/IDLE: out_valid=0, out_data=0, out_eop=0, in_ready=all 0, busy=0.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - Search in_valid round-robin, starting at last_grant+1 and wrapping modulo NUM_SRC.
  - If a requester is found, register grant_id=winner, beat_cnt=0, go to BUSY.
  - No requester: stay in IDLE.
  - Arbitration latency is exactly 1 cycle. No beat is ever transferred in the IDLE cycle.
- BUSY (all combinational from grant_id):
  - out_valid=in_valid[g], out_data=in_data[g].
  - out_eop = in_eop[g] OR (beat_cnt==MAX_BEATS-1).
  - in_ready[g]=out_ready; all other in_ready=0. busy=1.
  - A beat is accepted when out_valid & out_ready; on acceptance beat_cnt increments.
- Release:
  - The accepted beat with out_eop=1 causes: last_grant=g, state=IDLE, beat_cnt=0.
  - If in_eop[g]=0 on that beat (beat-limit release), trunc_count increments, saturating.
- Back-to-back packets: after a release there is always one IDLE cycle before any next grant, including a re-grant to the same source. Minimum packet spacing on the sink is 1 cycle.
- Withdrawn valid: if in_valid[g] drops mid-packet, stay in BUSY with out_valid=0. The lock is held and no other source is granted.
- out_ready=0: out_valid, out_data and out_eop follow the owning source unchanged; nothing is accepted and beat_cnt holds.
- Reset mid-packet: returns to IDLE immediately, and the partial packet is abandoned. The downstream sink must tolerate a missing EOP across reset.
- Single-beat packet (in_eop=1 on the first beat): grant cycle, then 1 transfer cycle, then IDLE.
- All counters and indices are unsigned. beat_cnt width is 8 bits.

Decomposition:
- Shared package avalon_st_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - the default DATA_W and MAX_BEATS constants;
  - a function rr_next(req, last) returning the next requester index.
- One natural sub-module: rr_picker.
  - Combinational; inputs request vector and last_grant; outputs found flag and winner index.
  - Reused by later schedulers.
- The top module holds the state register, grant register, beat counter and truncation counter.

Test Plan:
- Single source: after reset, src1 sends 3 beats 4,5,6 (eop on 6), out_ready=1.
  - Expect grant_id=1 one cycle after valid rises.
  - Sink sees 4,5,6 on 3 consecutive cycles with out_eop only on 6.
  - busy=0 on the next cycle.
- Round-robin fairness: src0, src1 and src2 all present 2-beat packets continuously.
  - Grant order is 0,1,2,0,...
  - Each packet is followed by exactly 1 idle cycle on the sink.
  - No interleaving of beats between sources.
- Backpressure: out_ready toggles 1,0,0,1,... during a 4-beat packet (data 0x10..0x13).
  - out_data holds while ready=0.
  - Exactly 4 accepts, and in_ready[g] mirrors out_ready.
- Beat limit: MAX_BEATS=4, src2 sends 6 beats with no eop.
  - 4th accepted beat shows out_eop=1; trunc_count becomes 1; arbiter returns to IDLE.
  - Remaining beats from src2 are re-arbitrated as a new packet.
- Withdrawn valid: src0 granted, in_valid[0] low for 3 cycles mid-packet while src1 is valid.
  - out_valid=0, grant stays 0, in_ready[1]=0 throughout.
  - Packet then completes normally.
- Reset mid-packet: assert resetn for 1 cycle after 2 of 5 beats.
  - Next cycle busy=0, out_valid=0, trunc_count=0.
  - Source 0 has priority on the next request.
